// File: rtl/alu_hs_pipe.sv
// Handshaked ALU with a registered result stage and an iterative restoring divider.
// The result register only loads when it is empty or being drained, so backpressure never drops a result.
module alu_hs_pipe #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  input  logic                  SIGNED_MODE,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  ZERO_FLAG,
  output logic                  ERR_FLAG
);

  localparam int W  = OPER_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int CW = $clog2(OPER_WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(OPER_WIDTH);
  localparam logic [OW-1:0] C_ONE    = OW'(1);
  localparam logic [OW-1:0] C_TWO    = OW'(2);
  localparam logic [OW-1:0] C_THREE  = OW'(3);
  localparam logic [3:0]    OP_DIV   = 4'b0011;

  typedef enum logic {
    S_IDLE,
    S_DIV_BUSY
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_divRem;
  logic [W-1:0]  r_divQuo;
  logic [W-1:0]  r_divDen;
  logic [CW-1:0] r_divCnt;

  logic          w_outLoad;
  logic          w_accept;
  logic          w_startDiv;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_stepRem;
  logic [W-1:0]  w_stepQuo;
  logic [OW-1:0] w_divOut;
  logic [OW-1:0] w_aExt;
  logic [OW-1:0] w_bExt;
  logic [OW-1:0] w_mulA;
  logic [OW-1:0] w_mulB;
  logic          w_gt;
  logic          w_lt;
  logic [OW-1:0] w_result;
  logic          w_err;

  assign w_outLoad  = !OUT_VALID || OUT_READY;
  assign IN_READY   = (r_state == S_IDLE) && w_outLoad && !RST;
  assign w_accept   = IN_VALID && IN_READY;
  assign w_startDiv = (ALU_FUN == OP_DIV) && (B != '0);

  // One restoring-division step: shift the next dividend bit in, subtract if it fits.
  assign w_shift   = {r_divRem, r_divQuo[W-1]};
  assign w_ge      = w_shift >= {1'b0, r_divDen};
  assign w_diff    = w_shift[W-1:0] - r_divDen;
  assign w_stepRem = w_ge ? w_diff : w_shift[W-1:0];
  assign w_stepQuo = {r_divQuo[W-2:0], w_ge};
  assign w_divOut  = (r_divCnt != '0) ? {w_stepRem, w_stepQuo} : {r_divRem, r_divQuo};

  assign w_aExt = {{W{1'b0}}, A};
  assign w_bExt = {{W{1'b0}}, B};
  assign w_mulA = SIGNED_MODE ? {{W{A[W-1]}}, A} : w_aExt;
  assign w_mulB = SIGNED_MODE ? {{W{B[W-1]}}, B} : w_bExt;
  assign w_gt   = SIGNED_MODE ? ($signed(A) > $signed(B)) : (A > B);
  assign w_lt   = SIGNED_MODE ? ($signed(A) < $signed(B)) : (A < B);

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (ALU_FUN)
      4'b0000: w_result = w_aExt + w_bExt;
      4'b0001: w_result = w_aExt - w_bExt;
      4'b0010: w_result = w_mulA * w_mulB;
      4'b0011: begin
        w_result = {A, {W{1'b1}}};
        w_err    = 1'b1;
      end
      4'b0100: w_result = {{W{1'b0}}, A & B};
      4'b0101: w_result = {{W{1'b0}}, A | B};
      4'b0110: w_result = {{W{1'b0}}, ~(A & B)};
      4'b0111: w_result = {{W{1'b0}}, ~(A | B)};
      4'b1000: w_result = {{W{1'b0}}, A ^ B};
      4'b1001: w_result = {{W{1'b0}}, ~(A ^ B)};
      4'b1010: w_result = (A == B) ? C_ONE : '0;
      4'b1011: w_result = w_gt ? C_TWO : '0;
      4'b1100: w_result = w_lt ? C_THREE : '0;
      4'b1101: w_result = {{W{1'b0}}, 1'b0, A[W-1:1]};
      4'b1110: w_result = {{(W-1){1'b0}}, A, 1'b0};
      default: w_result = {{W{1'b0}}, SIGNED_MODE & A[W-1], A[W-1:1]};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_divRem  <= '0;
      r_divQuo  <= '0;
      r_divDen  <= '0;
      r_divCnt  <= '0;
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      ZERO_FLAG <= 1'b0;
      ERR_FLAG  <= 1'b0;
    end else begin
      if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_startDiv) begin
              r_state  <= S_DIV_BUSY;
              r_divRem <= '0;
              r_divQuo <= A;
              r_divDen <= B;
              r_divCnt <= CNT_INIT;
            end else begin
              ALU_OUT   <= w_result;
              OUT_VALID <= 1'b1;
              ZERO_FLAG <= (w_result == '0);
              ERR_FLAG  <= w_err;
            end
          end
        end
        default: begin
          if (r_divCnt != '0) begin
            r_divRem <= w_stepRem;
            r_divQuo <= w_stepQuo;
            r_divCnt <= r_divCnt - CNT_ONE;
          end
          // The final step goes straight to the output; a finished result waits in the divider if blocked.
          if (((r_divCnt == CNT_ONE) || (r_divCnt == '0)) && w_outLoad) begin
            r_state   <= S_IDLE;
            ALU_OUT   <= w_divOut;
            OUT_VALID <= 1'b1;
            ZERO_FLAG <= (w_divOut == '0);
            ERR_FLAG  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hs_pipe.sv
// Directed self-checking bench for alu_hs_pipe with hand-computed expected values.
module tb_alu_hs_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_FUN;
  logic        SIGNED_MODE;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        ZERO_FLAG;
  logic        ERR_FLAG;

  int errorCount = 0;
  int checkCount = 0;

  alu_hs_pipe #(.OPER_WIDTH(8), .OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED_MODE(SIGNED_MODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ZERO_FLAG(ZERO_FLAG), .ERR_FLAG(ERR_FLAG)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b, input logic sm);
    ALU_FUN     = fun;
    A           = a;
    B           = b;
    SIGNED_MODE = sm;
    IN_VALID    = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0]  tFun [9] = '{4'hF, 4'hF, 4'hB, 4'hB, 4'hC, 4'hE, 4'h1, 4'h6, 4'h9};
  logic [7:0]  tA   [9] = '{8'h81, 8'h81, 8'h80, 8'h80, 8'h80, 8'h81, 8'h01, 8'hF0, 8'hF0};
  logic [7:0]  tB   [9] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h3C, 8'h3C};
  logic        tSm  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] tExp [9] = '{16'h00C0, 16'h0040, 16'h0000, 16'h0002, 16'h0003,
                            16'h0102, 16'hFFFF, 16'h00CF, 16'h0033};

  initial begin
    int lat;
    RST = 1'b1; A = '0; B = '0; ALU_FUN = '0; SIGNED_MODE = 1'b0;
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_alu_out", 32'(ALU_OUT), 32'd0);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
    checkOutput("rst_zero", 32'(ZERO_FLAG), 32'd0);
    checkOutput("rst_err", 32'(ERR_FLAG), 32'd0);
    RST = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(IN_READY), 32'd1);

    applyStimulus(4'b0000, 8'hFF, 8'h01, 1'b0);
    tick();
    checkOutput("b2b_add_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("b2b_add", 32'(ALU_OUT), 32'h0100);
    applyStimulus(4'b0010, 8'hFE, 8'h03, 1'b0);
    tick();
    checkOutput("b2b_mulu", 32'(ALU_OUT), 32'h02FA);
    checkOutput("b2b_mulu_valid", 32'(OUT_VALID), 32'd1);
    applyStimulus(4'b0010, 8'hFE, 8'h03, 1'b1);
    tick();
    checkOutput("b2b_muls", 32'(ALU_OUT), 32'hFFFA);
    IN_VALID = 1'b0;
    tick();
    checkOutput("b2b_drained", 32'(OUT_VALID), 32'd0);

    applyStimulus(4'b0011, 8'd200, 8'd7, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h01, 8'h01, 1'b0);
    lat = 1;
    while (!OUT_VALID && lat < 20) begin
      if (lat == 4) checkOutput("div_busy_in_ready", 32'(IN_READY), 32'd0);
      tick();
      lat++;
    end
    IN_VALID = 1'b0;
    checkOutput("div_latency", 32'(lat), 32'd9);
    checkOutput("div_result", 32'(ALU_OUT), 32'h041C);
    checkOutput("div_err", 32'(ERR_FLAG), 32'd0);
    tick();
    checkOutput("div_drained", 32'(OUT_VALID), 32'd0);

    applyStimulus(4'b0011, 8'h55, 8'h00, 1'b0);
    tick();
    IN_VALID = 1'b0;
    checkOutput("div0_valid", 32'(OUT_VALID), 32'd1);
    checkOutput("div0_result", 32'(ALU_OUT), 32'h55FF);
    checkOutput("div0_err", 32'(ERR_FLAG), 32'd1);
    tick();

    OUT_READY = 1'b0;
    applyStimulus(4'b1010, 8'h10, 8'h10, 1'b0);
    tick();
    checkOutput("bp_eq_result", 32'(ALU_OUT), 32'd1);
    checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
    applyStimulus(4'b0000, 8'h03, 8'h04, 1'b0);
    tick();
    tick();
    checkOutput("bp_held_result", 32'(ALU_OUT), 32'd1);
    checkOutput("bp_held_valid", 32'(OUT_VALID), 32'd1);
    OUT_READY = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    checkOutput("bp_next_result", 32'(ALU_OUT), 32'd7);
    checkOutput("bp_next_valid", 32'(OUT_VALID), 32'd1);
    tick();
    checkOutput("bp_drained", 32'(OUT_VALID), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(tFun[i], tA[i], tB[i], tSm[i]);
      tick();
      checkOutput($sformatf("vec%0d_out", i), 32'(ALU_OUT), 32'(tExp[i]));
      checkOutput($sformatf("vec%0d_zero", i), 32'(ZERO_FLAG), 32'(tExp[i] == 16'h0));
    end
    IN_VALID = 1'b0;
    tick();

    applyStimulus(4'b0011, 8'd200, 8'd7, 1'b0);
    tick();
    IN_VALID = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    checkOutput("rstmid_in_ready", 32'(IN_READY), 32'd0);
    tick();
    checkOutput("rstmid_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rstmid_alu_out", 32'(ALU_OUT), 32'd0);
    RST = 1'b0;
    #1;
    checkOutput("rstmid_ready_after", 32'(IN_READY), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("rstmid_aborted", 32'(OUT_VALID), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_hs_pipe.md
Name: alu_hs_pipe

Overview:
- Second-generation configurable ALU with valid/ready handshakes on both input and output.
- Adds an iterative multi-cycle divider that returns both quotient and remainder, a signed-operation mode, an arithmetic shift, and status flags.
- Sits between the register-file/control FSM and the result path; stalls cleanly under downstream backpressure.

Parameters:
OPER_WIDTH, 8, operand width in bits (>=2)
OUT_WIDTH, 2*OPER_WIDTH, result width; must equal 2*OPER_WIDTH

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
A  in  OPER_WIDTH  operand A
B  in  OPER_WIDTH  operand B
ALU_FUN  in  4  operation select
SIGNED_MODE  in  1  1 = two's-complement operands for multiply, compares and ASR
IN_VALID  in  1  operands/opcode valid
IN_READY  out  1  block can accept a new operation
ALU_OUT  out  OUT_WIDTH  result
OUT_VALID  out  1  ALU_OUT/flags valid
OUT_READY  in  1  consumer accepts result
ZERO_FLAG  out  1  ALU_OUT == 0
ERR_FLAG  out  1  divide by zero

Behaviour:
- Reset: synchronous, active-high on RST at the CLK edge. It aborts any operation, including a division in progress. State=IDLE; ALU_OUT=0; OUT_VALID=0; ZERO_FLAG=0; ERR_FLAG=0; divider registers=0. IN_READY is 0 while RST=1.
- Accept: occurs when IN_VALID && IN_READY at a CLK edge. A, B, ALU_FUN and SIGNED_MODE are captured at that edge.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). This is combinational and allows back-to-back throughput of 1 op/cycle for single-cycle ops.
- State machine:
  - IDLE -> DIV_BUSY on accepting opcode 0011 with B!=0.
  - DIV_BUSY: OPER_WIDTH cycles of restoring division, one quotient bit per cycle, MSB first. Then the result is written to the output register and state returns to IDLE.
  - All other accepts stay in IDLE.
- Latency: 1 cycle (OUT_VALID high the cycle after accept) for every op except divide with B!=0. That case takes OPER_WIDTH+1 cycles.
- Output register: loads only when empty or being drained in the same cycle. It holds ALU_OUT, ZERO_FLAG and ERR_FLAG stable while OUT_VALID && !OUT_READY. OUT_VALID drops after a transfer unless a new result loads on the same edge.
- ZERO_FLAG is computed from the loaded result. ERR_FLAG=0 except on divide-by-zero.
- Opcodes (operands zero-extended to OUT_WIDTH unless noted):
  - 0000: A+B. Carry appears in bit OPER_WIDTH.
  - 0001: A-B in OUT_WIDTH bits. A borrow yields a two's-complement wrap.
  - 0010: A*B. Unsigned, or signed full-width product when SIGNED_MODE=1.
  - 0011: divide, always unsigned. ALU_OUT = {remainder, quotient}, with the quotient in the low OPER_WIDTH bits.
    - B==0: 1-cycle latency, quotient = all ones, remainder = A, ERR_FLAG=1.
  - 0100: AND. 0101: OR. 0110: NAND. 0111: NOR. 1000: XOR. 1001: XNOR. Bitwise ops act on OPER_WIDTH bits; upper bits are 0.
  - 1010: 1 if A==B, else 0.
  - 1011: 2 if A>B, else 0.
  - 1100: 3 if A<B, else 0.
  - Compares 1011/1100 are signed when SIGNED_MODE=1.
  - 1101: logical shift right A>>1.
  - 1110: A<<1 in OUT_WIDTH bits, so bit OPER_WIDTH receives A's MSB.
  - 1111: A>>1. Arithmetic (sign-extended to OPER_WIDTH) when SIGNED_MODE=1, logical otherwise.
- IN_VALID during DIV_BUSY is ignored (IN_READY=0). Inputs may change freely while busy.
- A divide completion while the output register is full and not draining: the quotient/remainder stay in the divider registers, the state remains DIV_BUSY (complete), and the load happens on the first cycle the output is empty or draining.

Test Plan:
- Reset mid-op: accept 0011 A=200 B=7, assert RST at cycle 3 -> next edge OUT_VALID=0, ALU_OUT=0, IN_READY=1 the cycle after RST deasserts.
- Back-to-back, OUT_READY=1: 0000 A=0xFF B=0x01, then 0010 A=0xFE B=0x03 (SIGNED_MODE=0), then same multiply with SIGNED_MODE=1 -> outputs 0x0100, 0x02FA, 0xFFFA on consecutive cycles.
- Divide: 0011 A=200 B=7 -> OUT_VALID exactly 9 cycles after accept, ALU_OUT=0x041C, IN_READY=0 during busy.
- Divide by zero: 0011 A=0x55 B=0 -> next cycle ALU_OUT=0x55FF, ERR_FLAG=1.
- Backpressure: OUT_READY=0, issue 1010 A=B=0x10 -> ALU_OUT=1 held; IN_READY=0; a second op is not accepted until OUT_READY=1, after which the result transfers and the new op is accepted on the same edge.
- Shifts/compare/zero: 1111 A=0x81 SIGNED_MODE=1 -> 0x00C0; 1011 A=0x80 B=0x01 SIGNED_MODE=1 -> 0, ZERO_FLAG=1; 1110 A=0x81 -> 0x0102.
